// File: rtl/sample_loader.sv
// Receive-side sample RAM loader. Pairs UART bytes into big-endian 16-bit samples,
// writes them to consecutive RAM addresses and tracks progress, checksum and errors.
module sample_loader #(
  parameter int ADDR_W      = 14,
  parameter int DEPTH       = 16384,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              reset_key,
  input  logic              start,
  input  logic              stop,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [15:0]       ram_wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic [15:0]       checksum,
  output logic              overrun,
  output logic              timeout_err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W:0] LAST      = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] COUNT_ONE = (ADDR_W+1)'(1);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0]   TMO_ONE   = TW'(1);

  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO, DONE} state_t;

  state_t              state_reg, state_next;
  logic [7:0]          hi_reg, hi_next;
  logic [TW-1:0]       tmo_reg, tmo_next;
  logic [ADDR_W:0]     count_reg, count_next;
  logic [15:0]         sum_reg, sum_next;
  logic                wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0]   wr_addr_reg, wr_addr_next;
  logic [15:0]         wr_data_reg, wr_data_next;
  logic                ovr_reg, ovr_next;
  logic                tmo_err_reg, tmo_err_next;
  logic [15:0]         sample;

  assign sample = {hi_reg, rx_data};

  always_ff @(posedge clk or negedge reset_key) begin
    if (!reset_key) begin
      state_reg   <= IDLE;
      hi_reg      <= '0;
      tmo_reg     <= '0;
      count_reg   <= '0;
      sum_reg     <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      ovr_reg     <= 1'b0;
      tmo_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hi_reg      <= hi_next;
      tmo_reg     <= tmo_next;
      count_reg   <= count_next;
      sum_reg     <= sum_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
      ovr_reg     <= ovr_next;
      tmo_err_reg <= tmo_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    hi_next      = hi_reg;
    tmo_next     = tmo_reg;
    count_next   = count_reg;
    sum_next     = sum_reg;
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    ovr_next     = ovr_reg;
    tmo_err_next = tmo_err_reg;
    case (state_reg)
      IDLE, DONE: begin
        // start outranks a coincident byte, which is dropped without flagging overrun
        if (start) begin
          state_next   = WAIT_HI;
          hi_next      = '0;
          tmo_next     = '0;
          count_next   = '0;
          sum_next     = '0;
          wr_addr_next = '0;
          ovr_next     = 1'b0;
          tmo_err_next = 1'b0;
        end else if (rx_valid) begin
          ovr_next = 1'b1;
        end
      end
      WAIT_HI: begin
        if (stop) begin
          state_next = IDLE;
          hi_next    = '0;
        end else if (rx_valid) begin
          state_next = WAIT_LO;
          hi_next    = rx_data;
          tmo_next   = '0;
        end
      end
      WAIT_LO: begin
        if (stop) begin
          state_next = IDLE;
          hi_next    = '0;
          tmo_next   = '0;
        end else if (rx_valid) begin
          wr_en_next   = 1'b1;
          wr_addr_next = count_reg[ADDR_W-1:0];
          wr_data_next = sample;
          count_next   = count_reg + COUNT_ONE;
          sum_next     = sum_reg + sample;
          tmo_next     = '0;
          state_next   = (count_reg == LAST) ? DONE : WAIT_HI;
        end else if (tmo_reg == TMO_LAST) begin
          // idle for the full window: drop the half sample and wait for a new high byte
          state_next   = WAIT_HI;
          hi_next      = '0;
          tmo_next     = '0;
          tmo_err_next = 1'b1;
        end else begin
          tmo_next = tmo_reg + TMO_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ram_wr_en   = wr_en_reg;
  assign ram_wr_addr = wr_addr_reg;
  assign ram_wr_data = wr_data_reg;
  assign busy        = (state_reg == WAIT_HI) || (state_reg == WAIT_LO);
  assign done        = (state_reg == DONE);
  assign count       = count_reg;
  assign checksum    = sum_reg;
  assign overrun     = ovr_reg;
  assign timeout_err = tmo_err_reg;
endmodule

// File: tb/tb_sample_loader.sv
// Bench for sample_loader: directed scenarios with fixed expectations, then random
// traffic compared cycle by cycle against a frame-level reference model.
module tb_sample_loader;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;
  localparam int TMO    = 20;

  logic              clk = 1'b0;
  logic              reset_key;
  logic              start, stop, rx_valid;
  logic [7:0]        rx_data;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [15:0]       ram_wr_data;
  logic              busy, done;
  logic [ADDR_W:0]   count;
  logic [15:0]       checksum;
  logic              overrun, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: frame-level bookkeeping
  bit          m_busy, m_done, m_half, m_ovr, m_tmo, m_wr;
  logic [7:0]  m_hi;
  int          m_wait, m_count, m_addr;
  logic [15:0] m_sum, m_data;

  sample_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset_key(reset_key), .start(start), .stop(stop),
    .rx_data(rx_data), .rx_valid(rx_valid), .ram_wr_en(ram_wr_en),
    .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .busy(busy),
    .done(done), .count(count), .checksum(checksum), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_half = 0; m_ovr = 0; m_tmo = 0; m_wr = 0;
    m_hi = 0; m_wait = 0; m_count = 0; m_addr = 0; m_sum = 0; m_data = 0;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit v, input logic [7:0] d);
    m_wr = 0;
    if (!m_busy) begin
      if (st) begin
        m_busy = 1; m_done = 0; m_half = 0; m_count = 0; m_sum = 0;
        m_ovr = 0; m_tmo = 0;
      end else if (v) m_ovr = 1;
    end else if (sp) begin
      m_busy = 0; m_half = 0;
    end else if (!m_half) begin
      if (v) begin m_half = 1; m_hi = d; m_wait = 0; end
    end else if (v) begin
      m_wr = 1;
      m_addr = m_count % (1 << ADDR_W);
      m_data = {m_hi, d};
      m_sum = m_sum + m_data;
      m_count++;
      m_half = 0;
      if (m_count == DEPTH) begin m_busy = 0; m_done = 1; end
    end else begin
      m_wait++;
      if (m_wait == TMO) begin m_half = 0; m_tmo = 1; end
    end
  endtask

  task automatic compare_model();
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("count", 32'(count), 32'(m_count));
    check("checksum", 32'(checksum), 32'(m_sum));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("timeout_err", 32'(timeout_err), 32'(m_tmo));
    check("wr_en", 32'(ram_wr_en), 32'(m_wr));
    if (m_wr) begin
      check("wr_addr", 32'(ram_wr_addr), 32'(m_addr));
      check("wr_data", 32'(ram_wr_data), 32'(m_data));
    end
    $display("t=%0t st=%0b sp=%0b v=%0b d=%02h | wr=%0b a=%0d d=%04h busy=%0b done=%0b cnt=%0d sum=%04h ovr=%0b tmo=%0b",
             $time, start, stop, rx_valid, rx_data, ram_wr_en, ram_wr_addr, ram_wr_data,
             busy, done, count, checksum, overrun, timeout_err);
  endtask

  task automatic cycle(input bit st, input bit sp, input bit v, input logic [7:0] d);
    @(negedge clk);
    start = st; stop = sp; rx_valid = v; rx_data = d;
    @(posedge clk);
    model_step(st, sp, v, d);
    #1;
    compare_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 8'h00);
  endtask

  task automatic check_write(input string tag, input int addr, input logic [15:0] data);
    check({tag, "_en"}, 32'(ram_wr_en), 32'd1);
    check({tag, "_addr"}, 32'(ram_wr_addr), 32'(addr));
    check({tag, "_data"}, 32'(ram_wr_data), 32'(data));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, 32'(ram_wr_en), 0);
    check({tag, "_addr"}, 32'(ram_wr_addr), 0);
    check({tag, "_data"}, 32'(ram_wr_data), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_sum"}, 32'(checksum), 0);
    check({tag, "_ovr"}, 32'(overrun), 0);
    check({tag, "_tmo"}, 32'(timeout_err), 0);
  endtask

  initial begin
    reset_key = 1'b0; start = 0; stop = 0; rx_valid = 0; rx_data = 0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk) reset_key = 1'b1;

    // basic two-sample write
    cycle(1, 0, 0, 8'h00);
    cycle(0, 0, 1, 8'h12);
    cycle(0, 0, 1, 8'h34);
    check_write("w0", 0, 16'h1234);
    idle(1);
    check("w0_pulse", 32'(ram_wr_en), 0);
    cycle(0, 0, 1, 8'hAB);
    idle(2);
    cycle(0, 0, 1, 8'hCD);
    check_write("w1", 1, 16'hABCD);
    check("t1_count", 32'(count), 2);
    check("t1_sum", 32'(checksum), 32'h BE01);
    cycle(0, 1, 0, 8'h00);

    // full frame, back-to-back bytes
    cycle(1, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1, 8'(i));
      if (i % 2 == 1) check_write("frame", i / 2, {8'(i - 1), 8'(i)});
    end
    check("frame_done", 32'(done), 1);
    check("frame_busy", 32'(busy), 0);
    check("frame_sum", 32'(checksum), 32'h0C10);
    check("frame_count", 32'(count), DEPTH);
    cycle(0, 0, 1, 8'h5A);
    check("frame_ovr", 32'(overrun), 1);
    check("frame_nowr", 32'(ram_wr_en), 0);

    // inter-byte timeout and its boundary
    cycle(1, 0, 0, 8'h00);
    cycle(0, 0, 1, 8'hFF);
    idle(TMO - 1);
    check("tmo_early", 32'(timeout_err), 0);
    idle(1);
    check("tmo_fire", 32'(timeout_err), 1);
    check("tmo_nowr", 32'(ram_wr_en), 0);
    cycle(0, 0, 1, 8'h11);
    cycle(0, 0, 1, 8'h22);
    check_write("tmo_after", 0, 16'h1122);
    cycle(0, 0, 1, 8'h33);
    idle(TMO - 1);
    cycle(0, 0, 1, 8'h44);
    check_write("tmo_edge", 1, 16'h3344);
    cycle(0, 1, 0, 8'h00);

    // stop together with a low byte
    cycle(1, 0, 0, 8'h00);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 8'(8'h20 + i));
    cycle(0, 0, 1, 8'h90);
    cycle(0, 1, 1, 8'h99);
    check("stop_nowr", 32'(ram_wr_en), 0);
    check("stop_busy", 32'(busy), 0);
    check("stop_count", 32'(count), 3);
    check("stop_done", 32'(done), 0);
    cycle(1, 0, 0, 8'h00);
    check("restart_count", 32'(count), 0);
    cycle(0, 0, 1, 8'h01);
    cycle(0, 0, 1, 8'h02);
    check_write("restart", 0, 16'h0102);

    // asynchronous reset with a pending high byte
    cycle(0, 0, 1, 8'h77);
    #2 reset_key = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk) reset_key = 1'b1;
    cycle(0, 0, 1, 8'h55);
    check("rst_ovr", 32'(overrun), 1);
    check("rst_nowr", 32'(ram_wr_en), 0);

    // checksum wrap
    cycle(1, 0, 0, 8'h00);
    cycle(0, 0, 1, 8'hFF);
    cycle(0, 0, 1, 8'hFF);
    cycle(0, 0, 1, 8'h00);
    cycle(0, 0, 1, 8'h02);
    check("wrap_sum", 32'(checksum), 32'h0001);

    // random traffic against the model
    begin
      int pv;
      pv = 70;
      for (int n = 0; n < 2000; n++) begin
        bit st, sp, v;
        if (n % 64 == 0) pv = ($urandom_range(0, 2) == 0) ? 3 : 70;
        st = m_busy ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 7) == 0);
        sp = ($urandom_range(0, 79) == 0);
        v  = ($urandom_range(0, 99) < pv);
        cycle(st, sp, v, 8'($urandom));
      end
    end
    cycle(0, 0, 0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
